// File: rtl/struct_bank_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : struct_bank_arbiter_pkg
// Purpose  : Shared types and constants for the struct bank arbiter slice.
//            Defines the byte type, the bank address width, the number of
//            data bytes and the packed bank struct with two guard bytes.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package struct_bank_arbiter_pkg;

  localparam int NBYTES = 4;
  localparam int ADDR_W = 3;
  localparam int IDX_W  = $clog2(NBYTES);

  typedef logic [7:0]        byte_t;
  typedef logic [ADDR_W-1:0] addr_t;

  // Guard bytes bracket the data array; they only ever hold the fill value.
  typedef struct packed {
    byte_t                   msb;
    byte_t [0:NBYTES-1]      data;
    byte_t                   lsb;
  } bank_t;

  function automatic logic addr_in_range(input addr_t a);
    return (a < ADDR_W'(NBYTES));
  endfunction

  function automatic bank_t bank_fill(input byte_t v);
    bank_t b;
    b.msb = v;
    for (int i = 0; i < NBYTES; i++) begin
      b.data[i] = v;
    end
    b.lsb = v;
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/struct_bank_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Purpose  : Two-way round-robin arbiter. A sole requester is granted; when
//            both request, the one not granted most recently wins. Grants are
//            combinational and forced low while rst is high.
// Ports    : clk       - clock
//            rst       - synchronous active-high reset
//            req[1:0]  - request vector
//            gnt[1:0]  - one-hot (or zero) grant vector
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // State names which requester currently holds priority.
  localparam logic [0:0] c_pri0 = 1'b0;
  localparam logic [0:0] c_pri1 = 1'b1;

  logic [0:0] r_state;
  logic [0:0] w_state_next;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_pri0;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state: priority moves to the requester that was not just granted,
  // and only moves on cycles that carry a grant.
  always_comb begin
    w_state_next = r_state;
    if (gnt[0]) begin
      w_state_next = c_pri1;
    end else if (gnt[1]) begin
      w_state_next = c_pri0;
    end
  end

  // Output decode
  always_comb begin
    gnt = 2'b00;
    if (!rst) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (r_state == c_pri0) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/struct_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : struct_bank_arbiter
// Purpose  : Four-byte register bank shared by two requesters through a
//            round-robin arbiter. One access per cycle; every access gets a
//            one-cycle-latency response pulse on the granted requester's
//            rvalid with shared rdata/err.
// Ports    : clk, rst             - clock, synchronous active-high reset
//            req0/req1            - access requests
//            we0/we1              - 1 = write, 0 = read
//            addr0/addr1 [2:0]    - byte index, 4..7 out of range
//            wdata0/wdata1 [7:0]  - write data
//            gnt0/gnt1            - combinational grant pulses
//            rvalid0/rvalid1      - response pulses
//            rdata [7:0]          - read data (0 unless a read response)
//            err                  - out-of-range flag, aligned with rvalid
// Revision : 1.0 - initial release
// ============================================================================
module struct_bank_arbiter
  import struct_bank_arbiter_pkg::*;
#(
  parameter byte_t FILL = 8'hFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [7:0]        wdata0,
  input  logic [7:0]        wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [7:0]        rdata,
  output logic              err
);

  logic [1:0]       w_gnt;
  logic             w_any;
  logic             w_sel;
  logic             w_we;
  addr_t            w_addr;
  byte_t            w_wdata;
  logic [IDX_W-1:0] w_idx;

  bank_t            r_bank;
  logic [1:0]       r_rvalid;
  byte_t            r_rdata;
  logic             r_err;

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({req1, req0}),
    .gnt (w_gnt)
  );

  assign gnt0 = w_gnt[0];
  assign gnt1 = w_gnt[1];

  // Mux the granted requester's access onto a single internal port.
  assign w_any   = |w_gnt;
  assign w_sel   = w_gnt[1];
  assign w_we    = w_sel ? we1    : we0;
  assign w_addr  = w_sel ? addr1  : addr0;
  assign w_wdata = w_sel ? wdata1 : wdata0;
  assign w_idx   = w_addr[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bank   <= bank_fill(FILL);
      r_rvalid <= 2'b00;
      r_rdata  <= 8'h00;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= w_gnt;
      r_rdata  <= 8'h00;
      r_err    <= 1'b0;
      if (w_any) begin
        if (!addr_in_range(w_addr)) begin
          r_err <= 1'b1;
        end else if (w_we) begin
          r_bank.data[w_idx] <= w_wdata;
        end else begin
          r_rdata <= r_bank.data[w_idx];
        end
      end
    end
  end

  // A response registered in the cycle before reset rises would otherwise be
  // visible during the reset cycle; masking with rst drops it.
  assign rvalid0 = r_rvalid[0] & ~rst;
  assign rvalid1 = r_rvalid[1] & ~rst;
  assign rdata   = rst ? 8'h00 : r_rdata;
  assign err     = r_err & ~rst;

endmodule
`default_nettype wire

// File: tb/tb_struct_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_struct_bank_arbiter
// Purpose  : Scoreboard bench for struct_bank_arbiter. A driver issues
//            accesses, predicts grants and responses from a byte-array
//            reference model, and queues expected responses; a monitor pops
//            and compares whenever a response pulse appears.
// Revision : 1.0 - initial release
// ============================================================================
module tb_struct_bank_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, we0, we1;
  logic [2:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1, err;
  logic [7:0] rdata;

  always #5 clk = ~clk;

  struct_bank_arbiter #(.FILL(8'hFF)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .err(err)
  );

  typedef struct {
    int         id;
    logic [7:0] rdata;
    logic       err;
    int         due;
  } exp_t;

  exp_t       sbq[$];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;

  // Reference model state
  logic [7:0] mem [4];
  int         last_gnt;
  logic       m_rst;
  logic       p_req [2];
  logic       p_we [2];
  logic [2:0] p_addr [2];
  logic [7:0] p_wdata [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic issue(input int i, input logic we, input logic [2:0] a, input logic [7:0] d);
    p_req[i]   = 1'b1;
    p_we[i]    = we;
    p_addr[i]  = a;
    p_wdata[i] = d;
  endtask

  // One clock: drive pending accesses, then predict and check the grant.
  task automatic step();
    int   w;
    exp_t e;
    @(posedge clk);
    #1;
    rst    = m_rst;
    req0   = p_req[0];  we0 = p_we[0];  addr0 = p_addr[0];  wdata0 = p_wdata[0];
    req1   = p_req[1];  we1 = p_we[1];  addr1 = p_addr[1];  wdata1 = p_wdata[1];
    @(negedge clk);
    if (m_rst) begin
      chk("gnt_in_reset", {30'b0, gnt1, gnt0}, 32'd0);
      for (int k = 0; k < 4; k++) mem[k] = 8'hFF;
      last_gnt = 1;
    end else begin
      w = -1;
      if (p_req[0] && p_req[1]) w = (last_gnt == 0) ? 1 : 0;
      else if (p_req[0])        w = 0;
      else if (p_req[1])        w = 1;
      chk("gnt", {30'b0, gnt1, gnt0}, (w < 0) ? 32'd0 : (32'd1 << w));
      if (w >= 0) begin
        e.id  = w;
        e.due = cyc + 1;
        if (p_addr[w] >= 3'd4) begin
          e.rdata = 8'h00;
          e.err   = 1'b1;
        end else if (p_we[w]) begin
          mem[p_addr[w]] = p_wdata[w];
          e.rdata = 8'h00;
          e.err   = 1'b0;
        end else begin
          e.rdata = mem[p_addr[w]];
          e.err   = 1'b0;
        end
        sbq.push_back(e);
        p_req[w] = 1'b0;
        last_gnt = w;
      end
    end
  endtask

  task automatic run_until_idle(input int bound);
    int n = 0;
    while ((p_req[0] || p_req[1]) && n < bound) begin
      step();
      n++;
    end
    if (p_req[0] || p_req[1]) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout: requests still pending after %0d cycles", bound);
      p_req[0] = 1'b0;
      p_req[1] = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  // Monitor: every response pulse pops the oldest expected response.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst) begin
      chk("reset_outputs", {22'b0, rvalid1, rvalid0, err, rdata}, 32'd0);
      sbq.delete();
    end else if (rvalid0 || rvalid1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rvalid: got rvalid=%b%b expected none", rvalid1, rvalid0);
      end else begin
        e = sbq.pop_front();
        chk("rsp_id",      {30'b0, rvalid1, rvalid0}, 32'd1 << e.id);
        chk("rsp_rdata",   {24'b0, rdata}, {24'b0, e.rdata});
        chk("rsp_err",     {31'b0, err}, {31'b0, e.err});
        chk("rsp_latency", cyc, e.due);
      end
    end else begin
      chk("idle_rdata_err", {23'b0, err, rdata}, 32'd0);
      if (sbq.size() > 0 && sbq[0].due <= cyc) begin
        e = sbq.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_rvalid: got none expected rvalid for requester %0d", e.id);
      end
    end
  end

  initial begin
    rst = 1'b1; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    for (int i = 0; i < 2; i++) begin
      p_req[i] = 0; p_we[i] = 0; p_addr[i] = 0; p_wdata[i] = 0;
    end
    last_gnt = 1;

    // Reset with both requests high: no grants may appear.
    m_rst = 1'b1;
    issue(0, 1'b0, 3'd2, 8'h00);
    issue(1, 1'b0, 3'd1, 8'h00);
    idle(2);
    p_req[0] = 1'b0;
    p_req[1] = 1'b0;
    idle(1);
    m_rst = 1'b0;

    // First read after reset returns the fill value.
    issue(0, 1'b0, 3'd2, 8'h00);
    run_until_idle(4);
    idle(2);

    // Write then back-to-back reads.
    issue(0, 1'b1, 3'd1, 8'h7E);
    run_until_idle(4);
    issue(0, 1'b0, 3'd1, 8'h00);
    run_until_idle(4);
    issue(0, 1'b0, 3'd2, 8'h00);
    run_until_idle(4);
    idle(2);

    // Both requesters hold read requests from reset: grants alternate.
    m_rst = 1'b1;
    idle(1);
    m_rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 2; i++) if (!p_req[i]) issue(i, 1'b0, 3'(k), 8'h00);
      step();
      chk("rr_sequence", {30'b0, gnt1, gnt0}, (k % 2 == 0) ? 32'd1 : 32'd2);
    end
    p_req[0] = 1'b0;
    p_req[1] = 1'b0;
    idle(2);

    // Out-of-range write and read, then all bytes still at fill.
    issue(1, 1'b1, 3'd4, 8'h55);
    run_until_idle(4);
    issue(1, 1'b0, 3'd7, 8'h00);
    run_until_idle(4);
    for (int a = 0; a < 4; a++) begin
      issue(1, 1'b0, 3'(a), 8'h00);
      run_until_idle(4);
    end
    idle(2);

    // Contention on the same byte from reset: write first, then read.
    m_rst = 1'b1;
    idle(1);
    m_rst = 1'b0;
    issue(0, 1'b1, 3'd3, 8'hA5);
    issue(1, 1'b0, 3'd3, 8'h00);
    run_until_idle(4);
    idle(2);

    // Reset right after a granted write drops the response and the data.
    issue(0, 1'b1, 3'd0, 8'h3C);
    step();
    m_rst = 1'b1;
    step();
    m_rst = 1'b0;
    issue(0, 1'b0, 3'd0, 8'h00);
    run_until_idle(4);
    idle(2);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      m_rst = ($urandom_range(0, 49) == 0);
      for (int i = 0; i < 2; i++) begin
        if (!p_req[i] && $urandom_range(0, 2) != 0) begin
          issue(i, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 4) == 0) ? 3'(4 + $urandom_range(0, 3)) : 3'($urandom_range(0, 3)),
                8'($urandom));
        end
      end
      step();
    end
    m_rst = 1'b0;
    run_until_idle(20);
    idle(3);

    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d outstanding responses expected 0", sbq.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/struct_bank_arbiter.md
STRUCT_BANK_ARBITER -- requirements
Module: struct_bank_arbiter

Interface
REQ-001 Parameter: FILL, default 8'hFF, is the byte value loaded into every bank byte and both guard bytes at reset.
REQ-002 clk  input  1  is the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  is a synchronous, active-high reset.
REQ-004 req0 / req1  input  1  are the access requests from requesters 0 and 1.
REQ-005 we0 / we1  input  1  select the access type: 1 is write, 0 is read.
REQ-006 addr0 / addr1  input  3  are byte indices; 0..3 are valid, 4..7 are out of range.
REQ-007 wdata0 / wdata1  input  8  are the write data.
REQ-008 gnt0 / gnt1  output  1  are one-cycle grant pulses.
REQ-009 rvalid0 / rvalid1  output  1  are one-cycle response-valid pulses.
REQ-010 rdata  output  8  is the shared read-response data.
REQ-011 err  output  1  flags an out-of-range access, aligned with rvalid.

Function
REQ-012 Storage: one packed struct {msb byte, data[0:3] bytes, lsb byte}; msb and lsb are guard bytes held at FILL and never written.
REQ-013 At most one grant per cycle; gnt is combinational from req and the priority pointer.
REQ-014 Arbitration: sole requester is granted; if both request, the requester not granted most recently wins (round-robin).
REQ-015 Priority pointer: after reset, requester 0 has priority; the pointer toggles only on cycles with a grant.
REQ-016 Handshake: a requester holds req, we, addr and wdata stable until it sees gnt; the access is consumed in the gnt cycle.
REQ-017 Write: in a grant cycle with we=1 and addr<4, data[addr] takes wdata at the clock edge; no other byte changes.
REQ-018 Out-of-range write (addr>=4): no storage change; the response is err=1.
REQ-019 Read: in a grant cycle with we=0, data[addr] is registered; rvalid for the granted requester pulses the next cycle with rdata.
REQ-020 Latency: exactly 1 cycle from gnt to rvalid, for both reads and writes.
REQ-021 Write response: rvalid pulses with rdata=8'h00 and err=0.
REQ-022 Out-of-range access: rvalid pulses with err=1 and rdata=8'h00; rdata is never X.
REQ-023 When no rvalid is asserted, rdata=8'h00 and err=0.
REQ-024 Back-to-back: a grant is possible every cycle; a read granted the cycle after a write to the same byte returns the new value.
REQ-025 Contended requester waits at most 1 cycle: with both req held, grants alternate 0,1,0,1...

Reset
REQ-026 In a cycle with rst=1, the edge sets every struct byte to FILL, the pointer to requester 0, and rvalid0, rvalid1, err and rdata to 0.
REQ-027 gnt0 and gnt1 are forced to 0 while rst=1.
REQ-028 An access granted in the cycle before rst rises produces no rvalid after reset (the response is dropped).

Structure
REQ-029 Shared package: the bank struct typedef, a byte typedef, the NBYTES=4 constant and the bank address width.
REQ-030 Sub-module rr_arb2 is the two-way round-robin arbiter (req[1:0] -> gnt[1:0], pointer state); the bank and response logic stay in the top module.

Verification
REQ-031 After reset, req0 reads addr 2 -> gnt0 in cycle 0; next cycle rvalid0=1, rdata=8'hFF, err=0.
REQ-032 req0 writes 8'h7E to addr 1, then reads addr 1 and addr 2 -> rdata 8'h7E, then 8'hFF.
REQ-033 Both requesters hold read req from reset for 4 cycles -> gnt sequence 0,1,0,1; rvalid follows each by 1 cycle.
REQ-034 req1 writes addr 4, then reads addr 7 -> err=1 and rdata=8'h00 on both responses; all bytes remain 8'hFF.
REQ-035 Same cycle: req0 writes 8'hA5 to addr 3 and req1 reads addr 3 -> req0 is granted first, then req1 reads 8'hA5.
REQ-036 rst asserted the cycle after a grant -> no rvalid; a subsequent read of the written byte returns 8'hFF.
